muldiv_unit: RTL and testbench

Iterative, width-parametrised multiply/divide unit with HI/LO result registers for the five-stage CPU's EX stage. Implements MULT, MULTU, DIV and DIVU with one bit per cycle (shift-add multiply, restoring divide) behind a start/busy/done handshake. Supports MTHI/MTLO writes and a cancel input driven by the pipeline's branch flush. The pipeline stalls on `busy` whenever a later instruction reads HI/LO.

---
 rtl/muldiv_unit.sv | 197 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with HI/LO result registers.
// One bit per cycle: shift-add multiply, restoring divide, on the operand magnitudes.
// Signs are fixed up in a final FIX cycle.
// Optional feature macro: MULDIV_DIV_EN. When it is defined, DIV/DIVU are included.
// When it is undefined, the divide datapath is absent and divide starts are ignored.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;      // {upper, lower} working accumulator
    logic [WIDTH-1:0]   opb_q, opb_d;      // multiplicand / divisor magnitude
    logic               neg_q, neg_d;      // product or quotient must be negated
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

`ifdef MULDIV_DIV_EN
    logic               is_div_q, is_div_d;
    logic               neg_rem_q, neg_rem_d;  // remainder follows dividend sign
    logic               dz_q, dz_d;            // divide by zero: quotient forced to all ones
    logic [WIDTH:0]     div_rem;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_step;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
`endif

    logic               accept;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
    logic [2*WIDTH-1:0] step;
    logic [2*WIDTH-1:0] fix_wide;

    // Operand conditioning: signed ops (op[0]=0) work on absolute values.
    always_comb begin
        a_neg = ~op[0] & a[WIDTH-1];
        b_neg = ~op[0] & b[WIDTH-1];
        abs_a = a_neg ? -a : a;
        abs_b = b_neg ? -b : b;
`ifdef MULDIV_DIV_EN
        accept = start & ~cancel;
`else
        accept = start & ~cancel & ~op[1];
`endif
    end

    // One iteration of the selected algorithm on the accumulator.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_step = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        div_rem  = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff = div_rem - {1'b0, opb_q};
        div_step = div_diff[WIDTH] ? {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                   : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        step     = is_div_q ? div_step : mul_step;
`else
        step     = mul_step;
`endif
    end

    // Next-state, datapath and result write logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        fix_wide = neg_q ? -acc_q : acc_q;
`ifdef MULDIV_DIV_EN
        is_div_d  = is_div_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        quo_fix   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`endif
        case (state_q)
            S_IDLE: begin
                if (wr_hi) hi_d = wr_data;
                if (wr_lo) lo_d = wr_data;
                if (accept) begin
                    state_d = S_RUN;
                    cnt_d   = CW'(WIDTH - 1);
                    acc_d   = {{WIDTH{1'b0}}, abs_a};
                    opb_d   = abs_b;
                    neg_d   = a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
                    is_div_d  = op[1];
                    neg_rem_d = a_neg;
                    dz_d      = (b == '0);
`endif
                end
            end
            S_RUN: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = step;
                    if (cnt_q == '0) state_d = S_FIX;
                    else             cnt_d   = cnt_q - CW'(1);
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!cancel) begin
                    done_d = 1'b1;
`ifdef MULDIV_DIV_EN
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = dz_q ? '1 : quo_fix;
                    end else begin
                        hi_d = fix_wide[2*WIDTH-1:WIDTH];
                        lo_d = fix_wide[WIDTH-1:0];
                    end
`else
                    hi_d = fix_wide[2*WIDTH-1:WIDTH];
                    lo_d = fix_wide[WIDTH-1:0];
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div_q  <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef MULDIV_DIV_EN
            is_div_q  <= is_div_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven vectors plus hand sequences for cancel, MTHI/MTLO and reset.
// Expected results are queued at start and compared by a monitor on each done pulse.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cancel;
    logic         wr_hi;
    logic         wr_lo;
    logic [W-1:0] wr_data;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks   = 0;
    int failures = 0;

    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] mon_exp;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .cancel  (cancel),
        .wr_hi   (wr_hi),
        .wr_lo   (wr_lo),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 hi=%h lo=%h, required no done", hi, lo);
            end else begin
                mon_exp = exp_q.pop_front();
                check("result_hi", hi, mon_exp[2*W-1:W]);
                check("result_lo", lo, mon_exp[W-1:0]);
                check("busy_at_done", {31'b0, busy}, 32'd0);
                $display("txn done: hi=%h lo=%h (expected %h %h)", hi, lo,
                         mon_exp[2*W-1:W], mon_exp[W-1:0]);
            end
        end
    end

    // Called one step after the start edge; waits for done with a cycle budget.
    task automatic wait_done();
        int cyc;
        int busy_cnt;
        cyc      = 0;
        busy_cnt = 0;
        while (!done && cyc < 200) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done after %0d cycles, required %0d", cyc, W + 1);
        end else begin
            check("latency", cyc, W + 1);
            check("busy_cycles", busy_cnt, W + 1);
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] eh, input logic [W-1:0] el);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        exp_q.push_back({eh, el});
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();
    endtask

    initial begin
        logic [W-1:0]        rx;
        logic [W-1:0]        ry;
        logic [2*W-1:0]      up;
        logic signed [2*W-1:0] sp;

        rst_n = 1'b0; start = 1'b0; cancel = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        op = 2'b00; a = '0; b = '0; wr_data = '0;

        vecs.push_back('{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
        vecs.push_back('{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB});
        vecs.push_back('{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000});
        vecs.push_back('{2'b00, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB});
        vecs.push_back('{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001});
        vecs.push_back('{2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780});
`ifdef MULDIV_DIV_EN
        vecs.push_back('{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD});
        vecs.push_back('{2'b11, 32'd100,      32'd7,        32'h00000002, 32'h0000000E});
        vecs.push_back('{2'b11, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF});
        vecs.push_back('{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000});
        vecs.push_back('{2'b10, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF});
        vecs.push_back('{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD});
        vecs.push_back('{2'b10, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002});
        vecs.push_back('{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF});
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // MTHI then MTLO in IDLE
        wr_hi = 1'b1; wr_data = 32'h1234;
        @(posedge clk); #1;
        wr_hi = 1'b0; wr_lo = 1'b1; wr_data = 32'h5678;
        @(posedge clk); #1;
        wr_lo = 1'b0;
        check("mthi", hi, 32'h1234);
        check("mtlo", lo, 32'h5678);

        // MULTU 3x4, writes/start ignored while busy, cancel 10 cycles after start
        start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", {31'b0, busy}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; a = 32'd9; b = 32'd9; wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hDEAD;
        @(posedge clk); #1;
        start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        check("wr_hi_while_busy", hi, 32'h1234);
        check("wr_lo_while_busy", lo, 32'h5678);
        repeat (4) @(posedge clk);
        #1;
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        check("cancel_busy", {31'b0, busy}, 32'd0);
        check("cancel_done", {31'b0, done}, 32'd0);
        check("cancel_hi", hi, 32'h1234);
        check("cancel_lo", lo, 32'h5678);
        repeat (40) @(posedge clk);
        #1;
        check("cancel_hi_later", hi, 32'h1234);
        check("cancel_lo_later", lo, 32'h5678);

        // cancel beats a simultaneous start in IDLE
        start = 1'b1; cancel = 1'b1; op = 2'b01; a = 32'd5; b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        check("cancel_beats_start", {31'b0, busy}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        check("cancel_beats_start_lo", lo, 32'h5678);

        // start together with MTHI: write lands, result overwrites it later
        start = 1'b1; op = 2'b01; a = 32'd6; b = 32'd7; wr_hi = 1'b1; wr_data = 32'hAAAA;
        exp_q.push_back({32'd0, 32'd42});
        @(posedge clk); #1;
        start = 1'b0; wr_hi = 1'b0;
        check("start_and_mthi", hi, 32'hAAAA);
        wait_done();

        // Table vectors, issued back-to-back in the done cycle
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
        end

        // Random multiplies against a wide reference product
        for (int i = 0; i < 6; i++) begin
            rx = $urandom;
            ry = $urandom;
            if (i % 2 == 0) begin
                up = {32'b0, rx} * {32'b0, ry};
                run_op(2'b01, rx, ry, up[2*W-1:W], up[W-1:0]);
            end else begin
                sp = $signed({{W{rx[W-1]}}, rx}) * $signed({{W{ry[W-1]}}, ry});
                run_op(2'b00, rx, ry, sp[2*W-1:W], sp[W-1:0]);
            end
        end

        // Make HI/LO non-zero, then drop reset mid-RUN between edges
        run_op(2'b01, 32'h10000, 32'h10001, 32'h00000001, 32'h00010000);
        start = 1'b1; op = 2'b01; a = 32'h1234; b = 32'h5678;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_busy", {31'b0, busy}, 32'd0);
        check("async_reset_hi", hi, 32'd0);
        check("async_reset_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(2'b01, 32'd2, 32'd3, 32'd0, 32'd6);

`ifndef MULDIV_DIV_EN
        // Divide disabled: DIVU start is ignored
        start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        check("nodiv_busy", {31'b0, busy}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        check("nodiv_busy_later", {31'b0, busy}, 32'd0);
        check("nodiv_hi", hi, 32'd0);
        check("nodiv_lo", lo, 32'd6);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
